rr_packet_arbiter: RTL and testbench
====================================

Name: rr_packet_arbiter

Overview:
- Round-robin arbiter that shares one streaming output channel between NUM_REQ requesters.
- Packets are multi-beat. Once a requester wins, it owns the channel until its last beat transfers.
- Output is a one-hot grant plus its binary index, for downstream muxes and ID tagging.
- Sits in front of shared datapaths such as a memory port or bus master.

Parameters:
- NUM_REQ, 4: number of requesters; minimum 2.
- DATA_WIDTH, 32: width of each requester's data beat.
- IDX_WIDTH, $clog2(NUM_REQ): width of grant index (localparam).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester beat valid.
- in_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
- in_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_REQ  per-requester ready; equals gnt & {NUM_REQ{out_ready}}.
- out_valid  output  1  muxed beat valid.
- out_last  output  1  muxed last flag.
- out_data  output  DATA_WIDTH  muxed beat.
- out_ready  input  1  downstream ready.
- gnt  output  NUM_REQ  one-hot current grant; all zero when no owner.
- gnt_idx  output  IDX_WIDTH  binary index of gnt, bit 0 = index 0; 0 when gnt is zero.

Behaviour:
- State:
  - FSM with states ARB and LOCKED.
  - ptr: one-hot priority pointer.
  - own: registered one-hot owner.
  - Reset values: state=ARB, ptr=1 (requester 0 highest priority), own=0.
- While rst is high, gnt, in_ready, out_valid, out_last and gnt_idx read 0 and out_data reads 0.
- ARB state:
  - gnt is combinational, zero latency: the first set bit of in_valid scanning upward from the ptr position, wrapping NUM_REQ-1 -> 0.
  - If in_valid is 0, gnt=0 and out_valid=0.
- LOCKED state:
  - gnt=own regardless of other requests.
  - out_valid = in_valid[own]. A dropped valid from the owner produces a bubble and does not release the lock.
- Datapath:
  - out_data and out_last are AND-OR muxed by gnt (no priority logic).
  - out_valid = |(in_valid & gnt).
- Transfer: a transfer occurs on a cycle where out_valid && out_ready.
- Transitions:
  - ARB, transfer with out_last=1: stay ARB; single-beat packet complete.
  - ARB, out_valid and not (transfer with out_last): go LOCKED; own <= gnt. This also covers a stalled first beat, so a presented grant never changes while out_valid is high.
  - LOCKED, transfer with out_last=1: go ARB; own <= 0.
  - Otherwise: hold.
- Pointer update:
  - On every last-beat transfer, ptr <= gnt rotated left by 1, wrapping the MSB to bit 0. The winner becomes lowest priority.
  - ptr does not change on other cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Protocol assumptions on requesters, checked by assertions, not corrected:
  - A requester holds in_valid, in_data and in_last stable until accepted.
  - A valid, unaccepted requester does not drop in_valid.
- Assertions:
  - gnt is one-hot or zero.
  - gnt_idx matches gnt.
  - in_ready is never set for a non-granted requester.
- Simultaneous events: a new request arriving on the same cycle as a last-beat transfer is arbitrated the next cycle against the updated ptr.
- Reset mid-packet: the lock is abandoned and the next cycle arbitrates from requester 0. The partial packet downstream is the system's concern.

Test Plan:
- Single requester: in_valid=4'b0100, 3-beat packet, out_ready=1.
  - Requires gnt=0100 and gnt_idx=2 for 3 consecutive cycles, out_last on beat 3.
  - Then ptr=1000.
- All requesters valid, single-beat packets, out_ready=1 for 8 cycles.
  - Requires gnt_idx sequence 0,1,2,3,0,1,2,3.
- Lock hold: requester 1 sends a 4-beat packet while requesters 0 and 3 are valid throughout.
  - Requires gnt=0010 for all 4 beats.
  - Next grant is idx 3, then idx 0.
- Backpressure: out_ready=0 for 5 cycles after requester 2 presents a single beat, with requester 0 asserting mid-stall.
  - Requires gnt to stay 0100 and out_data stable.
  - Accept on out_ready=1; requester 0 wins the next cycle.
- Owner bubble: requester 3 is locked and drops in_valid for 2 cycles mid-packet while requester 0 is valid.
  - Requires out_valid=0 and gnt=1000 during the bubble.
  - No grant to requester 0 until requester 3's last beat.
- Reset mid-packet: assert rst for 1 cycle during requester 2's beat 2 while requesters 2 and 0 are valid.
  - Requires outputs 0 during rst.
  - Next cycle gnt=0001, since ptr is back at requester 0.

Source files
------------

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
//
// Round-robin arbiter that shares one streaming output channel between
// NUM_REQ requesters. Packets are multi-beat: once a requester wins it keeps
// the channel until its last beat transfers. The winner of each completed
// packet becomes the lowest-priority requester for the next arbitration.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   per-requester beat valid
//   in_last    per-requester last-beat flag
//   in_data    packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-requester ready (gnt gated by out_ready)
//   out_valid  muxed beat valid
//   out_last   muxed last flag
//   out_data   muxed beat
//   out_ready  downstream ready
//   gnt        one-hot current grant, zero when nobody owns the channel
//   gnt_idx    binary index of gnt, zero when gnt is zero
module rr_packet_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [IDX_WIDTH-1:0]          gnt_idx
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0]   own_reg, own_next;

  logic [NUM_REQ-1:0]   mask_hi;
  logic [NUM_REQ-1:0]   req_hi;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic                 xfer_last;

  logic [DATA_WIDTH-1:0] data_term [NUM_REQ];

  // Round-robin pick: requests at or above the pointer position take
  // precedence; if none, wrap to the lowest-numbered request. x & -x
  // isolates the lowest set bit.
  always_comb begin
    mask_hi = ~(ptr_reg - NUM_REQ'(1));
    req_hi  = in_valid & mask_hi;
    if (req_hi != '0) begin
      rr_gnt = req_hi & (~req_hi + NUM_REQ'(1));
    end else begin
      rr_gnt = in_valid & (~in_valid + NUM_REQ'(1));
    end
  end

  // Reset forces the grant to zero, which in turn zeroes every output
  // derived from it.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt = (state_reg == LOCKED) ? own_reg : rr_gnt;
    end
  end

  // AND-OR datapath mux: relies on gnt being one-hot or zero.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data_term
    assign data_term[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[gi]}};
  end

  always_comb begin
    out_data = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      out_data = out_data | data_term[i];
      if (gnt[i]) begin
        gnt_idx = gnt_idx | IDX_WIDTH'(i);
      end
    end
  end

  assign out_valid = |(in_valid & gnt);
  assign out_last  = |(in_last & gnt);
  assign in_ready  = gnt & {NUM_REQ{out_ready}};

  assign xfer_last = out_valid & out_ready & out_last;

  // Next-state: any presented beat that does not complete a packet locks the
  // grant, so a stalled first beat never sees its grant move.
  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ARB: begin
        if (!xfer_last && out_valid) begin
          state_next = LOCKED;
          own_next   = gnt;
        end
      end
      LOCKED: begin
        if (xfer_last) begin
          state_next = ARB;
          own_next   = '0;
        end
      end
      default: begin
        state_next = ARB;
        own_next   = '0;
      end
    endcase
    // Winner drops to lowest priority once its packet completes.
    if (xfer_last) begin
      ptr_next = {gnt[NUM_REQ-2:0], gnt[NUM_REQ-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB;
      ptr_reg   <= NUM_REQ'(1);
      own_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      own_reg   <= own_next;
    end
  end

  // Structural properties of the grant and requester protocol assumptions.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_idx_zero:   assert property (@(posedge clk) disable iff (rst) (gnt == '0) |-> (gnt_idx == '0));
  a_idx_match:  assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> gnt[gnt_idx]);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_checks
    a_ready_granted: assert property (@(posedge clk) disable iff (rst)
      in_ready[gi] |-> gnt[gi]);
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (in_valid[gi] && !in_ready[gi]) |=>
        (in_valid[gi] && $stable(in_last[gi]) &&
         $stable(in_data[gi*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
module tb_rr_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_last = '0;
  logic [N*DW-1:0]   in_data = '0;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic              out_ready = 1'b1;
  logic [N-1:0]      gnt;
  logic [1:0]        gnt_idx;

  rr_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready),
    .gnt(gnt), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mk(input int r, input int n);
    return {8'(r), 8'hA5, 16'(n)};
  endfunction

  task automatic set_req(input int r, input logic v, input logic l, input logic [31:0] d);
    in_valid[r] = v;
    in_last[r]  = l;
    in_data[r*DW +: DW] = d;
  endtask

  task automatic push(input int r, input logic l, input logic [31:0] d);
    exp_q.push_back('{idx: 2'(r), last: l, data: d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Scoreboard: every accepted beat must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got idx=%0d data=%h last=%b, required no transfer",
                 gnt_idx, out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (gnt_idx !== mon_e.idx || out_data !== mon_e.data || out_last !== mon_e.last) begin
          bad++;
          $display("FAIL xfer: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   gnt_idx, out_data, out_last, mon_e.idx, mon_e.data, mon_e.last);
        end else begin
          $display("xfer idx=%0d data=%h last=%b", gnt_idx, out_data, out_last);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 4'hF;
    in_last = 4'hF;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = mk(i, 9);
    tick;
    samp;
    total++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || in_ready !== 4'b0000 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b idx=%0d rdy=%b v=%b l=%b d=%h, required all zero",
               gnt, gnt_idx, in_ready, out_valid, out_last, out_data);
    end
    tick;
    in_valid = '0;
    tick;
    rst = 1'b0;
    samp;
    total++;
    if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got gnt=%b v=%b, required gnt=0000 v=0", gnt, out_valid);
    end
    tick;
  endtask

  task automatic test_single;
    do_reset;
    for (int b = 0; b < 3; b++) begin
      set_req(2, 1'b1, (b == 2), mk(2, b));
      push(2, (b == 2), mk(2, b));
      samp;
      total++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || out_last !== (b == 2)) begin
        bad++;
        $display("FAIL single_beat%0d: got gnt=%b idx=%0d last=%b, required gnt=0100 idx=2 last=%b",
                 b, gnt, gnt_idx, out_last, (b == 2));
      end
      tick;
    end
    // Probe the pointer: with requesters 0 and 3 valid, ptr=1000 picks 3.
    set_req(2, 1'b0, 1'b0, 32'h0);
    set_req(3, 1'b1, 1'b1, mk(3, 0));
    set_req(0, 1'b1, 1'b1, mk(0, 0));
    push(3, 1'b1, mk(3, 0));
    push(0, 1'b1, mk(0, 0));
    samp;
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL single_ptr: got gnt=%b, required 1000", gnt);
    end
    tick;
    set_req(3, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL single_wrap: got gnt=%b, required 0001", gnt);
    end
    tick;
    set_req(0, 1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness;
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, mk(i, 0));
    for (int k = 0; k < 8; k++) push(k % 4, 1'b1, mk(k % 4, k / 4));
    for (int k = 0; k < 8; k++) begin
      samp;
      total++;
      if (gnt_idx !== 2'(k % 4)) begin
        bad++;
        $display("FAIL fair_cycle%0d: got idx=%0d, required %0d", k, gnt_idx, k % 4);
      end
      tick;
      if (k < 4) set_req(k % 4, 1'b1, 1'b1, mk(k % 4, 1));
      else       set_req(k % 4, 1'b0, 1'b0, 32'h0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL fair_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_lock_hold;
    do_reset;
    for (int b = 0; b < 4; b++) push(1, (b == 3), mk(1, b));
    push(3, 1'b1, mk(3, 0));
    push(0, 1'b1, mk(0, 0));
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, (b == 3), mk(1, b));
      if (b == 1) begin
        set_req(0, 1'b1, 1'b1, mk(0, 0));
        set_req(3, 1'b1, 1'b1, mk(3, 0));
      end
      samp;
      total++;
      if (gnt !== 4'b0010) begin
        bad++;
        $display("FAIL lock_beat%0d: got gnt=%b, required 0010", b, gnt);
      end
      tick;
    end
    set_req(1, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt_idx !== 2'd3) begin
      bad++;
      $display("FAIL lock_next3: got idx=%0d, required 3", gnt_idx);
    end
    tick;
    set_req(3, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt_idx !== 2'd0) begin
      bad++;
      $display("FAIL lock_next0: got idx=%0d, required 0", gnt_idx);
    end
    tick;
    set_req(0, 1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL lock_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, mk(2, 7));
    push(2, 1'b1, mk(2, 7));
    push(0, 1'b1, mk(0, 7));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_req(0, 1'b1, 1'b1, mk(0, 7));
      samp;
      total++;
      if (gnt !== 4'b0100 || out_data !== mk(2, 7) || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall%0d: got gnt=%b v=%b d=%h, required gnt=0100 v=1 d=%h",
                 c, gnt, out_valid, out_data, mk(2, 7));
      end
      tick;
    end
    out_ready = 1'b1;
    samp;
    total++;
    if (gnt !== 4'b0100 || in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_accept: got gnt=%b rdy=%b, required 0100/0100", gnt, in_ready);
    end
    tick;
    set_req(2, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL bp_next: got gnt=%b, required 0001", gnt);
    end
    tick;
    set_req(0, 1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_owner_bubble;
    do_reset;
    for (int b = 0; b < 3; b++) push(3, (b == 2), mk(3, b));
    push(0, 1'b1, mk(0, 1));
    set_req(3, 1'b1, 1'b0, mk(3, 0));
    samp;
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL bubble_first: got gnt=%b, required 1000", gnt);
    end
    tick;
    set_req(0, 1'b1, 1'b1, mk(0, 1));
    set_req(3, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      samp;
      total++;
      if (out_valid !== 1'b0 || gnt !== 4'b1000) begin
        bad++;
        $display("FAIL bubble_gap%0d: got v=%b gnt=%b, required v=0 gnt=1000", c, out_valid, gnt);
      end
      tick;
    end
    for (int b = 1; b < 3; b++) begin
      set_req(3, 1'b1, (b == 2), mk(3, b));
      samp;
      total++;
      if (gnt !== 4'b1000) begin
        bad++;
        $display("FAIL bubble_beat%0d: got gnt=%b, required 1000", b, gnt);
      end
      tick;
    end
    set_req(3, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL bubble_release: got gnt=%b, required 0001", gnt);
    end
    tick;
    set_req(0, 1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bubble_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    push(2, 1'b0, mk(2, 0));
    push(2, 1'b0, mk(2, 1));
    push(0, 1'b1, mk(0, 5));
    push(2, 1'b1, mk(2, 2));
    set_req(2, 1'b1, 1'b0, mk(2, 0));
    samp;
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL rstmid_beat0: got gnt=%b, required 0100", gnt);
    end
    tick;
    set_req(2, 1'b1, 1'b0, mk(2, 1));
    set_req(0, 1'b1, 1'b1, mk(0, 5));
    samp;
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL rstmid_beat1: got gnt=%b, required 0100", gnt);
    end
    tick;
    set_req(2, 1'b1, 1'b1, mk(2, 2));
    rst = 1'b1;
    samp;
    total++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || in_ready !== 4'b0000 ||
        out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_zero: got gnt=%b idx=%0d rdy=%b v=%b l=%b d=%h, required all zero",
               gnt, gnt_idx, in_ready, out_valid, out_last, out_data);
    end
    tick;
    rst = 1'b0;
    samp;
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_after: got gnt=%b, required 0001", gnt);
    end
    tick;
    set_req(0, 1'b0, 1'b0, 32'h0);
    samp;
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL rstmid_resume: got gnt=%b, required 0100", gnt);
    end
    tick;
    set_req(2, 1'b0, 1'b0, 32'h0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_lock_hold;
    test_backpressure;
    test_owner_bubble;
    test_reset_mid;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
